// File: rtl/apb_cfg_master.sv
// apb_cfg_master: APB initiator for the rotate core's register block.
// Turns single-word valid/ready commands into APB SETUP/ACCESS transfers and
// returns one response pulse per command.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   -> ACCESS is aborted after TIMEOUT_CYC wait cycles (O_RSP_ERR=1)
//   undefined -> ACCESS waits indefinitely, O_RSP_ERR tied to 0
//
// Ports:
//   I_PCLK, I_PRESET_N            clock, synchronous active-low reset
//   I_CMD_VALID / O_CMD_READY     command handshake (READY follows I_PREADY in ACCESS)
//   I_CMD_WRITE/ADDR/WDATA        command fields, sampled on the accept edge only
//   O_RSP_VALID/RDATA/ERR         one-cycle response, no backpressure
//   O_BUSY                        state is not IDLE
//   O_PSEL/PENABLE/PWRITE/PADDR/PWDATA, I_PRDATA, I_PREADY   APB master side
module apb_cfg_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              I_PCLK,
    input  logic              I_PRESET_N,
    input  logic              I_CMD_VALID,
    output logic              O_CMD_READY,
    input  logic              I_CMD_WRITE,
    input  logic [ADDR_W-1:0] I_CMD_ADDR,
    input  logic [DATA_W-1:0] I_CMD_WDATA,
    output logic              O_RSP_VALID,
    output logic [DATA_W-1:0] O_RSP_RDATA,
    output logic              O_RSP_ERR,
    output logic              O_BUSY,
    output logic              O_PSEL,
    output logic              O_PENABLE,
    output logic              O_PWRITE,
    output logic [ADDR_W-1:0] O_PADDR,
    output logic [DATA_W-1:0] O_PWDATA,
    input  logic [DATA_W-1:0] I_PRDATA,
    input  logic              I_PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              load_c;
    logic              done_c;
    logic              abort_c;
    logic              timeout_hit;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // Legal TIMEOUT_CYC range is 1..255; this block only marks an illegal setting.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_cyc_out_of_range
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_err_q;

    // Counter holds the wait cycles already seen; this cycle would be number TO_LIM.
    assign timeout_hit = (wait_cnt_q == TO_LIM - CNT_W'(1));

    // Wait-cycle counter, cleared whenever a new transfer enters SETUP.
    always_ff @(posedge I_PCLK) begin
        if (!I_PRESET_N) begin
            wait_cnt_q <= '0;
        end else if (state_d == ST_SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !I_PREADY) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // Error flag follows the kind of termination of the last transfer.
    always_ff @(posedge I_PCLK) begin
        if (!I_PRESET_N) begin
            rsp_err_q <= 1'b0;
        end else if (done_c) begin
            rsp_err_q <= 1'b0;
        end else if (abort_c) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign O_RSP_ERR = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign O_RSP_ERR   = 1'b0;
`endif

    // Next-state, command accept and transfer termination decode.
    always_comb begin
        state_d     = state_q;
        O_CMD_READY = 1'b0;
        load_c      = 1'b0;
        done_c      = 1'b0;
        abort_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                O_CMD_READY = 1'b1;
                if (I_CMD_VALID) begin
                    load_c  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Completion edge can accept the next command to stream without IDLE.
                O_CMD_READY = I_PREADY;
                if (I_PREADY) begin
                    done_c = 1'b1;
                    if (I_CMD_VALID) begin
                        load_c  = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, APB address/data phase registers and response registers.
    always_ff @(posedge I_PCLK) begin
        if (!I_PRESET_N) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= done_c | abort_c;
            if (load_c) begin
                pwrite_q <= I_CMD_WRITE;
                paddr_q  <= I_CMD_ADDR & ~ADDR_W'(3);
                pwdata_q <= I_CMD_WDATA;
            end
            if (done_c) begin
                rsp_rdata_q <= pwrite_q ? '0 : I_PRDATA;
            end else if (abort_c) begin
                rsp_rdata_q <= '0;
            end
        end
    end

    assign O_BUSY      = (state_q != ST_IDLE);
    assign O_PSEL      = (state_q != ST_IDLE);
    assign O_PENABLE   = (state_q == ST_ACCESS);
    assign O_PWRITE    = pwrite_q;
    assign O_PADDR     = paddr_q;
    assign O_PWDATA    = pwdata_q;
    assign O_RSP_VALID = rsp_valid_q;
    assign O_RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Testbench for apb_cfg_master: random and directed commands against a
// word-addressed register-file model, with a scoreboard for responses and
// APB transfers, plus a small APB slave with per-transfer wait states.
module tb_apb_cfg_master;

    localparam int unsigned TO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        I_CMD_VALID, I_CMD_WRITE;
    logic [31:0] I_CMD_ADDR, I_CMD_WDATA;
    logic        O_CMD_READY, O_RSP_VALID, O_RSP_ERR, O_BUSY;
    logic [31:0] O_RSP_RDATA;
    logic        O_PSEL, O_PENABLE, O_PWRITE;
    logic [31:0] O_PADDR, O_PWDATA;
    logic [31:0] I_PRDATA;
    logic        I_PREADY;

    always #5 clk = ~clk;

    apb_cfg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .I_PCLK(clk), .I_PRESET_N(rst_n),
        .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
        .I_CMD_WRITE(I_CMD_WRITE), .I_CMD_ADDR(I_CMD_ADDR), .I_CMD_WDATA(I_CMD_WDATA),
        .O_RSP_VALID(O_RSP_VALID), .O_RSP_RDATA(O_RSP_RDATA), .O_RSP_ERR(O_RSP_ERR),
        .O_BUSY(O_BUSY), .O_PSEL(O_PSEL), .O_PENABLE(O_PENABLE), .O_PWRITE(O_PWRITE),
        .O_PADDR(O_PADDR), .O_PWDATA(O_PWDATA), .I_PRDATA(I_PRDATA), .I_PREADY(I_PREADY)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_t;

    rsp_t        rq[$];
    apb_t        aq[$];
    int          wq[$];
    logic [31:0] mmem [0:63];
    logic [31:0] smem [0:63];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_rsp = 0;
    int          wl = 0;
    int          run = 0;
    int          last_run = 0;
    logic        prev_psel = 1'b0;
    logic        prev_pen = 1'b0;
    rsp_t        mon_r;
    apb_t        mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (O_RSP_VALID) begin
            n_rsp++;
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 32'(1), 32'(0));
            end else begin
                mon_r = rq.pop_front();
                chk("rsp_rdata", O_RSP_RDATA, mon_r.rdata);
                chk("rsp_err", 32'(O_RSP_ERR), 32'(mon_r.err));
                chk("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
        end
    end

    // APB monitor: protocol ordering, transfer fields, and slave register writes.
    always @(negedge clk) begin
        if (O_PSEL && O_PENABLE && !prev_pen)
            chk("setup_before_access", 32'(prev_psel && !prev_pen), 32'(1));
        if (O_PSEL && O_PENABLE && I_PREADY) begin
            if (aq.size() == 0) begin
                chk("apb_unexpected", 32'(1), 32'(0));
            end else begin
                mon_a = aq.pop_front();
                chk("pwrite", 32'(O_PWRITE), 32'(mon_a.w));
                chk("paddr", O_PADDR, mon_a.addr);
                chk("pwdata", O_PWDATA, mon_a.wdata);
            end
            if (O_PWRITE) smem[O_PADDR[7:2]] = O_PWDATA;
        end
        if (O_PSEL) begin
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        prev_psel = O_PSEL;
        prev_pen  = O_PENABLE;
    end

    // APB slave: wait count per transfer comes from the stimulus side.
    initial begin
        I_PREADY = 1'b0;
        I_PRDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            I_PRDATA = $urandom;
            if (O_PSEL && !O_PENABLE) begin
                if (wq.size() != 0) wl = wq.pop_front();
                else wl = 0;
                I_PREADY = 1'b0;
            end else if (O_PSEL && O_PENABLE) begin
                if (wl == 0) begin
                    I_PREADY = 1'b1;
                    I_PRDATA = smem[O_PADDR[7:2]];
                end else begin
                    I_PREADY = 1'b0;
                    wl--;
                end
            end else begin
                I_PREADY = 1'b0;
            end
        end
    end

    // Present one command, wait for acceptance and record what it should produce.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input bit expect_rsp);
        bit         to;
        int         n;
        logic [5:0] idx;
        rsp_t       r;
        apb_t       p;
        I_CMD_WRITE = w;
        I_CMD_ADDR  = a;
        I_CMD_WDATA = d;
        I_CMD_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!O_CMD_READY && n < 1000);
        if (!O_CMD_READY) begin
            chk("cmd_accept_timeout", 32'(0), 32'(1));
            I_CMD_VALID = 1'b0;
            return;
        end
`ifdef APB_TIMEOUT_EN
        to = (waits >= int'(TO_CYC));
`else
        to = 1'b0;
`endif
        idx = a[7:2];
        wq.push_back(waits);
        if (expect_rsp) begin
            r.err   = to;
            r.rdata = (w || to) ? 32'h0 : mmem[idx];
            r.cyc   = cyc + 1 + (to ? int'(TO_CYC) + 1 : waits + 2);
            rq.push_back(r);
            if (!to) begin
                p.w = w;
                p.addr = {a[31:2], 2'b00};
                p.wdata = d;
                aq.push_back(p);
                if (w) mmem[idx] = d;
            end
        end
        @(posedge clk);
        #2;
        I_CMD_VALID = 1'b0;
        I_CMD_WRITE = 1'($urandom);
        I_CMD_ADDR  = $urandom;
        I_CMD_WDATA = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || O_BUSY) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(rq.size() == 0 && !O_BUSY), 32'(1));
        @(posedge clk);
        #2;
    endtask

    // Two-edge reset in the middle of a transfer, then check the idle state.
    task automatic reset_check();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_psel", 32'(O_PSEL), 32'(0));
        chk("rst_penable", 32'(O_PENABLE), 32'(0));
        chk("rst_busy", 32'(O_BUSY), 32'(0));
        chk("rst_cmd_ready", 32'(O_CMD_READY), 32'(1));
        chk("rst_rsp_valid", 32'(O_RSP_VALID), 32'(0));
        chk("rst_rsp_err", 32'(O_RSP_ERR), 32'(0));
        chk("rst_rsp_rdata", O_RSP_RDATA, 32'h0);
        chk("rst_paddr", O_PADDR, 32'h0);
        chk("rst_pwdata", O_PWDATA, 32'h0);
        chk("rst_pwrite", 32'(O_PWRITE), 32'(0));
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] sa [0:5];
        logic [31:0] sd [0:5];
        int          r0;
        int          n;
        sa[0] = 32'h04; sd[0] = 32'd7000;
        sa[1] = 32'h08; sd[1] = 32'd5;
        sa[2] = 32'h0C; sd[2] = 32'd8;
        sa[3] = 32'h18; sd[3] = 32'd2;
        sa[4] = 32'h1C; sd[4] = 32'd1;
        sa[5] = 32'h20; sd[5] = 32'd1;
        for (int i = 0; i < 64; i++) begin
            mmem[i] = '0;
            smem[i] = '0;
        end
        rst_n = 1'b0;
        I_CMD_VALID = 1'b0;
        I_CMD_WRITE = 1'b0;
        I_CMD_ADDR  = '0;
        I_CMD_WDATA = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_psel", 32'(O_PSEL), 32'(0));
        chk("init_busy", 32'(O_BUSY), 32'(0));
        chk("init_cmd_ready", 32'(O_CMD_READY), 32'(1));
        chk("init_rsp_valid", 32'(O_RSP_VALID), 32'(0));
        @(posedge clk);
        #2;

        // Single zero-wait write.
        issue(1'b1, 32'h00, 32'd20, 0, 1'b1);
        drain();

        // Streamed writes with no idle gap, then read them back.
        r0 = n_rsp;
        for (int i = 0; i < 6; i++) issue(1'b1, sa[i], sd[i], 0, 1'b1);
        drain();
        @(negedge clk);
        chk("stream_rsp_count", 32'(n_rsp - r0), 32'(6));
        chk("stream_psel_run", 32'(last_run), 32'(12));
        @(posedge clk);
        #2;
        for (int i = 0; i < 6; i++) issue(1'b0, sa[i], 32'h0, int'($urandom_range(0, 3)), 1'b1);
        drain();

        // Read with three wait states from an unaligned address.
        issue(1'b1, 32'h10, 32'd8, 0, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 3, 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
                  int'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
        end
        drain();

`ifdef APB_TIMEOUT_EN
        // Ready arriving on the abort edge completes normally; a stuck slave aborts.
        issue(1'b0, 32'h10, 32'h0, int'(TO_CYC) - 1, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 50, 1'b1);
        drain();
        issue(1'b0, 32'h08, 32'h0, 1000000, 1'b0);
        n = 0;
        while (!O_PENABLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_access", 32'(O_PENABLE), 32'(1));
        reset_check();
`else
        // Without the timeout a stuck slave holds the transfer in ACCESS.
        issue(1'b0, 32'h20, 32'h0, 1000000, 1'b0);
        repeat (100) @(negedge clk);
        chk("hang_busy", 32'(O_BUSY), 32'(1));
        chk("hang_psel", 32'(O_PSEL), 32'(1));
        chk("hang_penable", 32'(O_PENABLE), 32'(1));
        reset_check();
`endif

        // Recovery after reset.
        issue(1'b1, 32'h30, 32'hA5A5_0F0F, 1, 1'b1);
        issue(1'b0, 32'h31, 32'h0, 2, 1'b1);
        drain();
        repeat (5) @(negedge clk);
        chk("end_rsp_queue", 32'(rq.size()), 32'(0));
        chk("end_apb_queue", 32'(aq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
